cam_gray_decimator: RTL



---
 rtl/cam_gray_decimator_if.sv | 30 +++
 rtl/cam_gray_decimator.sv | 115 +++++++++++
 2 files changed

// File: rtl/cam_gray_decimator_if.sv
// Port bundle for cam_gray_decimator: the camera pixel stream going in and the
// grayscale byte stream with its status signals coming out.
interface cam_gray_decimator_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic          frame_valid;
    logic          pixel_valid;
    logic [9:0]    pixel_x;
    logic [9:0]    pixel_y;
    logic [15:0]   pixel_data;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready;
    logic          frame_start;
    logic          overflow;
    logic [LW-1:0] fifo_level;

    // master: the camera side plus the byte consumer; slave: the decimator
    modport master (
        output frame_valid, pixel_valid, pixel_x, pixel_y, pixel_data, out_ready,
        input  out_data, out_valid, frame_start, overflow, fifo_level
    );

    modport slave (
        input  frame_valid, pixel_valid, pixel_x, pixel_y, pixel_data, out_ready,
        output out_data, out_valid, frame_start, overflow, fifo_level
    );
endinterface

// File: rtl/cam_gray_decimator.sv
// Decimates an RGB565 pixel stream to one grayscale byte per H_SCALE x V_SCALE
// block and queues the bytes, with a 0xFF frame marker, in a FWFT FIFO.
module cam_gray_decimator #(
    parameter int         H_SCALE    = 8,
    parameter int         V_SCALE    = 8,
    parameter int         IMG_W      = 640,
    parameter int         IMG_H      = 480,
    parameter int         FIFO_DEPTH = 16,
    parameter logic [7:0] SYNC_BYTE  = 8'hFF
) (
    input logic                 clk,
    input logic                 rst,
    cam_gray_decimator_if.slave bus
);
    localparam int         AW     = $clog2(FIFO_DEPTH);
    localparam int         LW     = AW + 1;
    localparam logic [9:0] H_MASK = 10'(H_SCALE - 1);
    localparam logic [9:0] V_MASK = 10'(V_SCALE - 1);

    logic          frame_valid_d;
    logic          rise;
    logic          keep;
    logic [7:0]    r8, g8, b8;
    logic [15:0]   sum;
    logic [7:0]    gray_raw;
    logic [7:0]    gray_next;
    logic          gray_valid;
    logic [7:0]    gray_byte;
    logic          wr_req;
    logic [7:0]    wr_data;
    logic          push;
    logic          pop;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic          overflow_q;

    // rst gating keeps frame_start low while reset is held with frame_valid high
    assign rise = bus.frame_valid & ~frame_valid_d & ~rst;

    assign keep = bus.pixel_valid & bus.frame_valid & frame_valid_d
                & ((bus.pixel_x & H_MASK) == 10'd0)
                & ((bus.pixel_y & V_MASK) == 10'd0)
                & ({1'b0, bus.pixel_x} < 11'(IMG_W))
                & ({1'b0, bus.pixel_y} < 11'(IMG_H));

    assign r8 = {bus.pixel_data[15:11], bus.pixel_data[15:13]};
    assign g8 = {bus.pixel_data[10:5],  bus.pixel_data[10:9]};
    assign b8 = {bus.pixel_data[4:0],   bus.pixel_data[4:2]};
    assign sum = 16'd77  * {8'd0, r8}
               + 16'd150 * {8'd0, g8}
               + 16'd29  * {8'd0, b8};
    assign gray_raw  = 8'(sum >> 8);
    // 0xFF is reserved for the frame marker
    assign gray_next = (gray_raw == 8'hFF) ? 8'hFE : gray_raw;

    // Sync and gray writes cannot coincide: a kept pixel needs frame_valid_d,
    // which is low in every rise cycle.
    assign wr_req  = rise | gray_valid;
    assign wr_data = rise ? SYNC_BYTE : gray_byte;

    // Byte stream: a byte transfers on each clock edge where out_valid and
    // out_ready are both high; out_data is held while out_valid & ~out_ready.
    assign pop  = (level != '0) & bus.out_ready;
    assign push = wr_req & ((level < LW'(FIFO_DEPTH)) | pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_valid_d <= 1'b0;
            gray_valid    <= 1'b0;
            gray_byte     <= 8'd0;
        end else begin
            frame_valid_d <= bus.frame_valid;
            gray_valid    <= keep;
            gray_byte     <= gray_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (wr_req & ~push) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign bus.out_valid   = (level != '0);
    assign bus.out_data    = (level != '0) ? mem[rd_ptr] : 8'd0;
    assign bus.frame_start = rise;
    assign bus.overflow    = overflow_q;
    assign bus.fifo_level  = level;
endmodule
